geo_ram_seq: RTL
================

# geo_ram_seq

GeoRAM memory sequencer sitting directly downstream of the Block/Window register stage in the cartridge CPLD. Each PHI2 cycle it turns a C64 access to the 256-byte page window into a registered 22-bit DRAM address and a read/write command. In cycles with no window access it schedules CBR refresh from a refresh-debt counter. Its outputs feed the DRAM pin driver, which executes one command during the PHI2-high phase that follows each rising edge.

## Interface
Parameters:
- REF_INTERVAL, 15: PHI2 cycles per refresh credit (15 cycles at about 1 MHz gives 4096 rows in under 64 ms).
- DEBT_W, 4: width of the refresh-debt counter; maximum debt is 2^DEBT_W-1.
- ROW_W, 12: refresh row counter width.

Ports:
- PHI2  in  1  C64 PHI2; the only clock; all state updates on the rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- RamSEL  in  1  window access in progress (page-window I/O select decoded upstream).
- nWE  in  1  C64 R/W; 0 = write.
- A  in  8  C64 A[7:0], byte offset within the window.
- Block  in  8  block register from the register stage.
- Window  in  6  window register from the register stage.
- Cmd  out  2  00 IDLE, 01 READ, 10 WRITE, 11 REFRESH.
- RamAddr  out  22  {Block, Window, A} latched for the current access.
- RefRow  out  ROW_W  row being refreshed when Cmd=REFRESH.
- RefOverflow  out  1  sticky flag: refresh debt was lost.

## Operation
Internal state:
- ivl: interval counter, 0..REF_INTERVAL-1.
- debt: refresh debt, DEBT_W bits.
- row: refresh row counter, ROW_W bits.
- Output registers Cmd, RamAddr, RefRow, RefOverflow.

Per rising edge of PHI2, in priority order:
- **Access.** When RamSEL=1:
  - Cmd <= nWE ? READ : WRITE.
  - RamAddr <= {Block, Window, A}.
  - Refresh is never issued in an access cycle.
- **Refresh.** Otherwise, when debt != 0:
  - Cmd <= REFRESH.
  - RefRow <= row.
  - row <= row+1, wrapping from 2^ROW_W-1 to 0.
  - debt decrements.
- **Idle.** Otherwise Cmd <= IDLE.

RamAddr changes only on access cycles; it holds in IDLE and REFRESH cycles. RefRow changes only on refresh cycles.

Interval and debt accounting:
- ivl increments every cycle and wraps from REF_INTERVAL-1 to 0. The wrap generates one credit.
- Credit without a refresh issued in the same cycle: debt+1. If debt is already at 2^DEBT_W-1, debt holds and RefOverflow <= 1.
- Credit and refresh issued in the same cycle: debt unchanged. The saturation check does not apply.
- RefOverflow clears only on reset.

Register-stage coupling:
- Block and Window are written by the upstream stage on the falling edge, so they are stable at the rising edge.
- A register write in cycle n affects RamAddr from the first access sampled at or after rising edge n+1. A write to the registers is not itself a window access; RamSEL must be 0 for register writes.

Reset (nRESET=0, asynchronous):
- Cmd=IDLE, RamAddr=0, RefRow=0, RefOverflow=0.
- ivl=0, debt=0, row=0.
- A command in flight is abandoned immediately.
- The first command after release is evaluated at the first rising edge with nRESET=1.

## Timing
- Latency: inputs sampled at rising edge n produce Cmd/RamAddr valid from edge n until edge n+1. That is one command per PHI2 cycle, registered, with no combinational input-to-output path.
- Consecutive access cycles are allowed with no gap. Refresh fills idle cycles only.
- First credit after reset: ivl reaches REF_INTERVAL-1 at edge REF_INTERVAL, so debt=1 after edge 15. The first REFRESH is issued at edge 16 if RamSEL=0.
- Steady idle: one REFRESH every REF_INTERVAL cycles, with rows incrementing.
- Sustained access: debt grows by 1 per REF_INTERVAL cycles. Overflow occurs after (2^DEBT_W)·REF_INTERVAL = 240 starved cycles with the defaults.
- Debt drains back-to-back, one REFRESH per idle cycle, until debt=0.

## Test plan
- **Reset.** Assert nRESET mid-REFRESH with debt=3 → outputs immediately go to Cmd=00, RamAddr=0, RefRow=0, RefOverflow=0. After release, no REFRESH occurs before edge 16.
- **Read/write.** Block=0xA5, Window=0x2C, A=0x7F, RamSEL=1:
  - nWE=1 → Cmd=01, RamAddr=0x296C7F.
  - Next cycle nWE=0, A=0x80 → Cmd=10, RamAddr=0x296C80.
  - RamSEL=0 → Cmd=00 with RamAddr held.
- **Idle refresh cadence.** 60 idle cycles after reset → REFRESH at edges 16, 31, 46 with RefRow 0, 1, 2; Cmd=00 at all other edges.
- **Starvation and drain.** RamSEL=1 for 240 cycles, then 0:
  - RefOverflow=0 through edge 239 and 1 from edge 240; debt stays at 15.
  - Then 15 consecutive REFRESH cycles with RefOverflow still 1.
- **Row wrap.** Preload row to 4095 via idle run → RefRow 4095, then 0 on the next REFRESH.
- **Register update timing.** Window changes on the falling edge between two back-to-back accesses → the first access uses the old Window and the second uses the new one. A credit wrap coinciding with a REFRESH leaves debt unchanged.

Source files
------------

// File: rtl/geo_ram_seq.sv
// GeoRAM memory sequencer: turns page-window accesses into registered DRAM
// commands and fills idle PHI2 cycles with CBR refresh drawn from a debt counter.
module geo_ram_seq #(
  parameter int REF_INTERVAL = 15,
  parameter int DEBT_W       = 4,
  parameter int ROW_W        = 12
) (
  input  logic             PHI2,
  input  logic             nRESET,
  input  logic             RamSEL,
  input  logic             nWE,
  input  logic [7:0]       A,
  input  logic [7:0]       Block,
  input  logic [5:0]       Window,
  output logic [1:0]       Cmd,
  output logic [21:0]      RamAddr,
  output logic [ROW_W-1:0] RefRow,
  output logic             RefOverflow
);

  localparam int IVL_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  localparam logic [1:0] CMD_IDLE    = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  logic [IVL_W-1:0]  ivlR;
  logic [DEBT_W-1:0] debtR;
  logic [ROW_W-1:0]  rowR;

  logic              ivlWrapS;
  logic              refreshS;
  logic [1:0]        cmdNextS;
  logic [DEBT_W-1:0] debtNextS;
  logic              ovfSetS;

  assign ivlWrapS = (ivlR == IVL_W'(REF_INTERVAL - 1));
  assign refreshS = !RamSEL && (debtR != DEBT_W'(0));

  // Command selection: a window access always wins over refresh.
  always_comb begin
    cmdNextS = CMD_IDLE;
    if (RamSEL) begin
      cmdNextS = nWE ? CMD_READ : CMD_WRITE;
    end else if (refreshS) begin
      cmdNextS = CMD_REFRESH;
    end else begin
      cmdNextS = CMD_IDLE;
    end
  end

  // Debt accounting: a credit paired with a refresh cancels out, so saturation only matters for an unpaid credit.
  always_comb begin
    debtNextS = debtR;
    ovfSetS   = 1'b0;
    if (ivlWrapS && !refreshS) begin
      if (&debtR) begin
        ovfSetS = 1'b1;
      end else begin
        debtNextS = debtR + DEBT_W'(1);
      end
    end else if (!ivlWrapS && refreshS) begin
      debtNextS = debtR - DEBT_W'(1);
    end else begin
      debtNextS = debtR;
    end
  end

  // Interval, debt and row counters.
  always_ff @(posedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      ivlR  <= IVL_W'(0);
      debtR <= DEBT_W'(0);
      rowR  <= ROW_W'(0);
    end else begin
      ivlR  <= ivlWrapS ? IVL_W'(0) : ivlR + IVL_W'(1);
      debtR <= debtNextS;
      if (cmdNextS == CMD_REFRESH) begin
        rowR <= rowR + ROW_W'(1);
      end
    end
  end

  // Registered outputs to the DRAM pin driver; address and row hold outside their own cycles.
  always_ff @(posedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      Cmd         <= CMD_IDLE;
      RamAddr     <= 22'd0;
      RefRow      <= ROW_W'(0);
      RefOverflow <= 1'b0;
    end else begin
      Cmd <= cmdNextS;
      if (RamSEL) begin
        RamAddr <= {Block, Window, A};
      end
      if (cmdNextS == CMD_REFRESH) begin
        RefRow <= rowR;
      end
      if (ovfSetS) begin
        RefOverflow <= 1'b1;
      end
    end
  end

endmodule
